// File: rtl/seg_pkg.sv
// Shared 7-segment glyph encodings (active-low, bit order g..a) and the code-to-glyph decoder.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] CODE_DASH = 4'hA;

   // Codes B..F have no glyph and render as blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] glyph;
      case (code)
         4'h0:      glyph = SEG_0;
         4'h1:      glyph = SEG_1;
         4'h2:      glyph = SEG_2;
         4'h3:      glyph = SEG_3;
         4'h4:      glyph = SEG_4;
         4'h5:      glyph = SEG_5;
         4'h6:      glyph = SEG_6;
         4'h7:      glyph = SEG_7;
         4'h8:      glyph = SEG_8;
         4'h9:      glyph = SEG_9;
         CODE_DASH: glyph = SEG_DASH;
         default:   glyph = SEG_BLANK;
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of one 4-bit digit code into its active-low g..a segment pattern.
module seg7_decode
   import seg_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] glyph
);

   assign glyph = seg_decode(code);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed, double-buffered driver for an N_DIG-digit common-anode 7-segment display,
// with a blanking window at the start of every digit slot to suppress ghosting.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int F_CLK      = 50_000_000,
   parameter int F_CLK_SLOW = 1000,
   parameter int N_DIG      = 8,
   parameter int DEAD       = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4*N_DIG-1:0]   digits,
   input  logic [N_DIG-1:0]     dp_mask,
   output logic [N_DIG-1:0]     cs,
   output logic [7:0]           o_dig_sel,
   output logic                 frame_done
);

   localparam int DIV   = F_CLK / F_CLK_SLOW;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_DIG - 1);

   if (DEAD < 0 || DEAD >= DIV) begin : g_bad_dead
      $error("seg_scan_driver: DEAD must satisfy 0 <= DEAD < DIV");
   end
   if (N_DIG < 1 || N_DIG > 8) begin : g_bad_ndig
      $error("seg_scan_driver: N_DIG must be in 1..8");
   end

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [4*N_DIG-1:0] shadow_dig_q, shadow_dig_d;
   logic [N_DIG-1:0]   shadow_dp_q, shadow_dp_d;
   logic [N_DIG-1:0]   cs_q, cs_d;
   logic [7:0]         seg_q, seg_d;
   logic               frame_done_q, frame_done_d;

   logic               frame_start, cnt_wrap;
   logic [3:0]         cur_code;
   logic               cur_dp;
   logic [N_DIG-1:0]   cur_sel;
   logic [6:0]         cur_glyph;

   // Digit selection reads the next shadow value so that a frame-start capture is visible
   // immediately, which keeps the first slot correct even when there is no dead time.
   always_comb begin
      frame_start  = (cnt_q == '0) && (idx_q == '0);
      cnt_wrap     = (cnt_q == CNT_MAX);
      cnt_d        = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
      idx_d        = idx_q;
      if (cnt_wrap) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      end
      shadow_dig_d = frame_start ? digits  : shadow_dig_q;
      shadow_dp_d  = frame_start ? dp_mask : shadow_dp_q;

      cur_code = 4'hF;
      cur_dp   = 1'b0;
      cur_sel  = '0;
      for (int i = 0; i < N_DIG; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_code   = shadow_dig_d[4*i +: 4];
            cur_dp     = shadow_dp_d[i];
            cur_sel[i] = 1'b1;
         end
      end
   end

   seg7_decode u_decode (
      .code  (cur_code),
      .glyph (cur_glyph)
   );

   always_comb begin
      cs_d         = '1;
      seg_d        = 8'hFF;
      frame_done_d = cnt_wrap && (idx_q == IDX_MAX);
      if (cnt_q >= CNT_DEAD) begin
         cs_d  = ~cur_sel;
         seg_d = {~cur_dp, cur_glyph};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_dig_q <= '1;
         shadow_dp_q  <= '0;
         cs_q         <= '1;
         seg_q        <= 8'hFF;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_dig_q <= shadow_dig_d;
         shadow_dp_q  <= shadow_dp_d;
         cs_q         <= cs_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign cs         = cs_q;
   assign o_dig_sel  = seg_q;
   assign frame_done = frame_done_q;

endmodule
